apb_master_bridge: RTL
======================

# apb_master_bridge

APB initiator that converts a simple valid/ready request stream into APB3 transfers and returns one response per transfer. It is the bus-side counterpart of the audioport's APB register interface. Test-harness and system-integration logic use it to drive configuration, command, DSP-coefficient and audio-buffer writes and status reads. It sequences SETUP/ACCESS phases, honours slave wait states (including the command-register wait states), reports PSLVERR, and aborts transfers that stall past a timeout.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: maximum ACCESS-phase cycles before abort. 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on an edge where req_valid=1 and req_ready=1.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data.
- rsp_valid  out  1  one-cycle response strobe; there is no backpressure.
- rsp_rdata  out  32  read data. It is 0 for writes and timeouts.
- rsp_err  out  1  PSLVERR seen, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- busy  out  1  state is not IDLE.
- PSEL, PENABLE, PWRITE  out  1  APB controls; registered.
- PADDR, PWDATA  out  32  APB address and data; registered.
- PRDATA  in  32; PREADY  in  1; PSLVERR  in  1.

## Operation
States: IDLE, SETUP, ACCESS.

- **IDLE**
  - PSEL=0, PENABLE=0, req_ready=1.
  - On accept, latch req_write, req_addr and req_wdata into PWRITE, PADDR and PWDATA.
  - Next state is SETUP.
- **SETUP**
  - PSEL=1, PENABLE=0, req_ready=0.
  - Clear wait_ctr.
  - Next state is ACCESS, unconditionally.
- **ACCESS**
  - PSEL=1, PENABLE=1.
  - req_ready = PREADY.
  - PADDR, PWDATA and PWRITE are held stable through SETUP and all of ACCESS.
- **ACCESS with PREADY=1 (completion)**
  - Capture PRDATA into rsp_rdata for reads. For writes, rsp_rdata is 0.
  - Capture PSLVERR into rsp_err. rsp_timeout=0.
  - Pulse rsp_valid on the next cycle.
  - If a request is accepted in this same cycle, latch it and go directly to SETUP. This gives back-to-back transfers: PSEL stays 1, PENABLE toggles 0,1,0,1.
  - Otherwise go to IDLE.
- **ACCESS with PREADY=0**
  - wait_ctr increments. It is $clog2(TIMEOUT_CYCLES+1) bits wide and saturates at TIMEOUT_CYCLES.
  - If TIMEOUT_CYCLES≠0 and wait_ctr==TIMEOUT_CYCLES-1, abort:
    - next cycle PSEL=0, PENABLE=0, state IDLE;
    - rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - req_ready=0 on the abort cycle.
- PREADY=1 in the final allowed cycle is a normal completion, not a timeout.
- In IDLE, PADDR, PWDATA and PWRITE hold their last values.
- busy = (state≠IDLE).

## Timing
- **Reset values:**
  - PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0.
  - busy=0, req_ready=1 (state IDLE), wait_ctr=0.
- **Latency:** accept at edge 0 gives SETUP in cycle 1 and ACCESS in cycle 2.
  - With zero wait states, PREADY is sampled at the end of cycle 2 and rsp_valid appears in cycle 3.
  - Each wait state adds one cycle.
- **Throughput:** 2 cycles per transfer when back-to-back with zero wait states.
- rsp_valid is high for exactly one cycle per accepted request. rsp_rdata, rsp_err and rsp_timeout are valid only while rsp_valid=1 and hold until the next response.
- **Reset mid-transfer:** rst=1 in any state means that on the next cycle:
  - state is IDLE, PSEL=0, PENABLE=0;
  - no rsp_valid is issued for the abandoned transfer;
  - a response pending for the following cycle is cancelled.
- rst has priority over completion, timeout and accept.
- PREADY and PRDATA are ignored outside ACCESS.

## Test plan
- **Single write, zero wait:** addr 0x0000_0004, data 0xA5A5_0001, PREADY=1.
  - PSEL=1 in cycles 1–2; PENABLE=1 in cycle 2; PADDR=0x4 stable.
  - rsp_valid in cycle 3 with rsp_err=0 and rsp_rdata=0.
- **Read with 3 wait states:** PREADY=0 for 3 ACCESS cycles, then PREADY=1 with PRDATA=0x1234_5678.
  - ACCESS lasts 4 cycles.
  - rsp_rdata=0x1234_5678, rsp_err=0.
- **Back-to-back writes:** req_valid held for 2 writes (0x10→0x1, 0x14→0x2), PREADY=1.
  - PSEL continuously 1 for 4 cycles; PENABLE 0,1,0,1.
  - Second request accepted in the first completion cycle.
  - Two rsp_valid pulses, 2 cycles apart.
- **Slave error:** PSLVERR=1 with PREADY=1 on a read.
  - rsp_err=1, rsp_timeout=0, rsp_rdata=PRDATA.
- **Timeout:** TIMEOUT_CYCLES=16, PREADY held 0.
  - ACCESS lasts exactly 16 cycles, then PSEL drops.
  - rsp_valid with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - The next request proceeds normally.
- **Reset in ACCESS:** assert rst for 1 cycle during a wait-stated read.
  - Next cycle PSEL=0, PENABLE=0, req_ready=1, busy=0.
  - No rsp_valid is ever seen for that read.

Source files
------------

// File: rtl/apb_master_bridge.sv
// apb_master_bridge
//   APB3 initiator. Accepts one request per valid/ready handshake, runs the
//   SETUP/ACCESS sequence, honours slave wait states, and returns a single
//   one-cycle response per accepted request. ACCESS phases that stall past
//   TIMEOUT_CYCLES are aborted and reported as a timeout error.
//
//   state  | meaning
//   IDLE   | no transfer; req_ready=1, PSEL=0
//   SETUP  | first APB phase; PSEL=1, PENABLE=0, wait counter cleared
//   ACCESS | second APB phase; PSEL=1, PENABLE=1, waiting for PREADY
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/ready/write/addr/wdata   request stream
//   rsp_valid/rdata/err/timeout        response strobe and payload
//   busy                        state is not IDLE
//   PSEL..PWDATA                registered APB master outputs
//   PRDATA, PREADY, PSLVERR     APB slave inputs
module apb_master_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        rsp_timeout,
   output logic        busy,
   output logic        PSEL,
   output logic        PENABLE,
   output logic        PWRITE,
   output logic [31:0] PADDR,
   output logic [31:0] PWDATA,
   input  logic [31:0] PRDATA,
   input  logic        PREADY,
   input  logic        PSLVERR
);

   // A zero timeout still needs a 1-bit counter to keep the code legal.
   localparam int unsigned    CTR_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CTR_W-1:0] CTR_MAX  = CTR_W'(TIMEOUT_CYCLES);
   localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic           TO_EN    = (TIMEOUT_CYCLES > 0);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CTR_W-1:0] wait_ctr_q, wait_ctr_d;
   logic             psel_q, psel_d;
   logic             penable_q, penable_d;
   logic             pwrite_q, pwrite_d;
   logic [31:0]      paddr_q, paddr_d;
   logic [31:0]      pwdata_q, pwdata_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [31:0]      rsp_rdata_q, rsp_rdata_d;
   logic             rsp_err_q, rsp_err_d;
   logic             rsp_timeout_q, rsp_timeout_d;
   logic             accept;

   always_comb begin
      state_d       = state_q;
      wait_ctr_d    = wait_ctr_q;
      pwrite_d      = pwrite_q;
      paddr_d       = paddr_q;
      pwdata_d      = pwdata_q;
      rsp_valid_d   = 1'b0;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;
      req_ready     = 1'b0;
      accept        = 1'b0;

      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept  = 1'b1;
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            wait_ctr_d = '0;
            state_d    = S_ACCESS;
         end
         S_ACCESS: begin
            if (PREADY) begin
               req_ready     = 1'b1;
               rsp_valid_d   = 1'b1;
               rsp_rdata_d   = pwrite_q ? 32'h0 : PRDATA;
               rsp_err_d     = PSLVERR;
               rsp_timeout_d = 1'b0;
               if (req_valid) begin
                  accept  = 1'b1;
                  state_d = S_SETUP;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               if (wait_ctr_q < CTR_MAX) begin
                  wait_ctr_d = wait_ctr_q + CTR_W'(1);
               end
               if (TO_EN && (wait_ctr_q == CTR_LAST)) begin
                  state_d       = S_IDLE;
                  rsp_valid_d   = 1'b1;
                  rsp_rdata_d   = 32'h0;
                  rsp_err_d     = 1'b1;
                  rsp_timeout_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (accept) begin
         pwrite_d = req_write;
         paddr_d  = req_addr;
         pwdata_d = req_wdata;
      end

      // APB controls are registered copies of the next state, so they line
      // up with the state register without any output decode glitches.
      psel_d    = (state_d != S_IDLE);
      penable_d = (state_d == S_ACCESS);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         wait_ctr_q    <= '0;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         pwrite_q      <= 1'b0;
         paddr_q       <= 32'h0;
         pwdata_q      <= 32'h0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= 32'h0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_ctr_q    <= wait_ctr_d;
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         pwrite_q      <= pwrite_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign PSEL        = psel_q;
   assign PENABLE     = penable_q;
   assign PWRITE      = pwrite_q;
   assign PADDR       = paddr_q;
   assign PWDATA      = pwdata_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;

endmodule
